// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load alignment unit between the LSU and the data-memory bus
//
// Accepts one load at a time, issues one or two NB-aligned bus reads, extracts
// the addressed bytes and sign/zero-extends them before handing the result to
// writeback.
//
// Build option: LOAD_ALIGN_MISALIGN_EN
//   defined   - loads crossing a bus word are split into two bus beats
//   undefined - loads crossing a bus word skip the bus and return a fault
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              load request handshake
//   req_addr, req_mem_op, req_rd     byte address, {ignored[1:0], signed, size[1:0]}, tag
//   bus_req_valid/bus_req_ready      bus read request handshake
//   bus_addr                         NB-aligned read address
//   bus_rsp_valid, bus_rsp_data      read response (little-endian)
//   wb_valid/wb_ready                writeback handshake
//   wb_data, wb_rd, misalign_fault   extended result, tag, split-load fault
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_mem_op,
    input  logic [4:0]        req_rd,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        wb_rd,
    output logic              misalign_fault
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(2 * XLEN);

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, WB} state_t;

    state_t            state, state_nxt;
    logic [OW-1:0]     off_r;
    logic [1:0]        size_r;
    logic              sgn_r;
    logic [4:0]        rd_r;
    logic              split_r;
    logic              illegal_r;
    logic [XLEN-1:0]   lo_r;

    logic [OW-1:0]     req_off;
    logic [1:0]        req_size;
    logic [4:0]        req_bytes;
    logic              req_illegal;
    logic              req_split;
    logic              accept;
    logic              unused_bits;

    logic [XLEN-1:0]   ext_lo, ext_hi;
    logic [2*XLEN-1:0] sh;
    logic [6:0]        nbits;
    logic [XLEN-1:0]   mask, field, ext_data;
    logic              sign;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign unused_bits = &{req_mem_op[4:3], 1'b0};

    assign req_off     = req_addr[OW-1:0];
    assign req_size    = req_mem_op[1:0];
    assign req_bytes   = 5'd1 << req_size;
    // A doubleword on a 32-bit bus is a single dummy beat returning zero.
    assign req_illegal = (XLEN == 32) && (req_size == 2'b11);
    assign req_split   = !req_illegal && ((5'(req_off) + req_bytes) > 5'(NB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
`ifdef LOAD_ALIGN_MISALIGN_EN
                state_nxt = REQ0;
`else
                state_nxt = req_split ? WB : REQ0;
`endif
            end
            REQ0: if (bus_req_ready) state_nxt = RSP0;
            RSP0: if (bus_rsp_valid) state_nxt = split_r ? REQ1 : WB;
            REQ1: if (bus_req_ready) state_nxt = RSP1;
            RSP1: if (bus_rsp_valid) state_nxt = WB;
            WB:   if (wb_ready)      state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Extraction works straight off the incoming response beat so the result
    // can be registered on the same edge that ends the last read.
    always_comb begin
        ext_lo   = (state == RSP1) ? lo_r : bus_rsp_data;
        ext_hi   = (state == RSP1) ? bus_rsp_data : '0;
        sh       = {ext_hi, ext_lo} >> {off_r, 3'b000};
        nbits    = 7'd8 << size_r;
        mask     = ~({XLEN{1'b1}} << nbits);
        sign     = sh[SW'(nbits - 7'd1)];
        field    = sh[XLEN-1:0] & mask;
        ext_data = field;
        if (illegal_r)          ext_data = '0;
        else if (sgn_r && sign) ext_data = field | ~mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_r          <= '0;
            size_r         <= '0;
            sgn_r          <= 1'b0;
            rd_r           <= '0;
            split_r        <= 1'b0;
            illegal_r      <= 1'b0;
            lo_r           <= '0;
            bus_req_valid  <= 1'b0;
            bus_addr       <= '0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            misalign_fault <= 1'b0;
        end else begin
            if (accept) begin
                off_r     <= req_off;
                size_r    <= req_size;
                sgn_r     <= req_mem_op[2];
                rd_r      <= req_rd;
                split_r   <= req_split;
                illegal_r <= req_illegal;
            end
            if (state == RSP0 && bus_rsp_valid)
                lo_r <= bus_rsp_data;

            bus_req_valid <= (state_nxt == REQ0) || (state_nxt == REQ1);
            if (state == IDLE && state_nxt == REQ0)
                bus_addr <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            else if (state == RSP0 && state_nxt == REQ1)
                bus_addr <= bus_addr + ADDR_W'(NB);

            wb_valid <= (state_nxt == WB);
            if (state != WB && state_nxt == WB) begin
                if (state == IDLE) begin
                    // Split load with splitting disabled: fault without a bus access.
                    wb_data        <= '0;
                    wb_rd          <= req_rd;
                    misalign_fault <= 1'b1;
                end else begin
                    wb_data        <= ext_data;
                    wb_rd          <= rd_r;
                    misalign_fault <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - randomized scoreboard bench for load_align_unit
module tb_load_align_unit;
    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [31:0] req_addr = '0;
    logic [4:0] req_mem_op = '0;
    logic [4:0] req_rd = '0;
    logic bus_req_valid;
    logic bus_req_ready = 1'b0;
    logic [31:0] bus_addr;
    logic bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_data = '0;
    logic wb_valid;
    logic wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0] wb_rd;
    logic misalign_fault;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mem_op(req_mem_op), .req_rd(req_rd),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .misalign_fault(misalign_fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory image: explicit entries for directed cases, hash elsewhere.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] addr, input int bytes, input bit sgn);
        logic [63:0] v;
        logic [31:0] a;
        logic [31:0] w;
        v = 0;
        for (int i = 0; i < bytes; i++) begin
            a = addr + 32'(i);
            w = mem_rd(a & ~32'(NB - 1));
            v = v | (64'((w >> ((a % NB) * 8)) & 32'hFF) << (8 * i));
        end
        if (sgn && v[8 * bytes - 1]) v = v | ~((64'd1 << (8 * bytes)) - 1);
        return v[31:0];
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [31:0] bus_q[$];

    task automatic model(input logic [31:0] addr, input logic [4:0] op, input logic [4:0] rd);
        int bytes;
        logic [31:0] base;
        bit split;
        wb_exp_t e;
        bytes = 1 << op[1:0];
        base = addr & ~32'(NB - 1);
        split = ((addr % NB) + bytes) > NB;
        e.rd = rd;
        e.fault = 1'b0;
        e.data = '0;
        if (bytes > NB) begin
            bus_q.push_back(base);
        end else if (split) begin
`ifdef LOAD_ALIGN_MISALIGN_EN
            bus_q.push_back(base);
            bus_q.push_back(base + 32'(NB));
            e.data = load_value(addr, bytes, op[2]);
`else
            e.fault = 1'b1;
`endif
        end else begin
            bus_q.push_back(base);
            e.data = load_value(addr, bytes, op[2]);
        end
        wb_q.push_back(e);
    endtask

    // Bus responder, ready generation and writeback monitor.
    int bus_rdy_mode = 2;
    int wb_rdy_mode = 2;
    bit fast = 1'b0;
    bit rsp_hold = 1'b0;
    bit pend = 1'b0;
    int delay = 0;
    logic [31:0] pend_addr = '0;
    int wb_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            bus_rsp_valid = 1'b0;
            bus_req_ready = 1'b0;
            wb_ready = 1'b0;
        end else begin
            bus_rsp_valid = 1'b0;
            bus_rsp_data = $urandom;
            if (pend) begin
                if (delay == 0 && !rsp_hold) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_data = mem_rd(pend_addr);
                    pend = 1'b0;
                end else if (delay > 0) begin
                    delay--;
                end
            end else if (!fast && $urandom_range(0, 3) == 0) begin
                bus_rsp_valid = 1'b1;
            end
            bus_req_ready = (bus_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(bus_rdy_mode);
            if (bus_req_valid && bus_req_ready) begin
                if (bus_q.size() == 0) fail_now("unexpected_bus_req");
                else chk("bus_addr", bus_addr, bus_q.pop_front());
                pend = 1'b1;
                delay = fast ? 0 : $urandom_range(0, 2);
                pend_addr = bus_addr;
            end
            wb_ready = (wb_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(wb_rdy_mode);
            if (wb_valid && wb_ready) begin
                wb_exp_t e;
                wb_count++;
                if (wb_q.size() == 0) begin
                    fail_now("unexpected_wb");
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", wb_rd, e.rd);
                    chk("misalign_fault", misalign_fault, e.fault);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [4:0] op, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            fail_now("req_ready_timeout");
        end else begin
            req_valid = 1'b1;
            req_addr = addr;
            req_mem_op = op;
            req_rd = rd;
            model(addr, op, rd);
            @(negedge clk);
            req_valid = 1'b0;
            req_addr = $urandom;
            req_mem_op = 5'($urandom);
            req_rd = 5'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wb_q.size() != 0 || !req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout");
    endtask

    // Issue with all readies high and zero-wait responses; measure cycles to wb_valid.
    task automatic lat_test(input logic [31:0] addr, input logic [4:0] op, input logic [4:0] rd,
                            input int exp_lat, input logic exp_bus);
        int n;
        fast = 1'b1;
        bus_rdy_mode = 1;
        wb_rdy_mode = 1;
        repeat (2) @(negedge clk);
        issue(addr, op, rd);
        chk("bus_req_valid_t1", bus_req_valid, exp_bus);
        n = 1;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        drain();
        fast = 1'b0;
        bus_rdy_mode = 2;
        wb_rdy_mode = 2;
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] d0;
        logic [4:0]  r0;
        int c0;
        int n;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_bus_req_valid", bus_req_valid, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_fault", misalign_fault, 0);

        mem[32'h1000] = 32'h80FF1234;
        lat_test(32'h1003, 5'b00100, 5'd1, 3, 1'b1);
        mem[32'h1000] = 32'hBEEF0000;
        lat_test(32'h1002, 5'b00001, 5'd2, 3, 1'b1);
        mem[32'h1000] = 32'h44332211;
        mem[32'h1004] = 32'h88776655;
`ifdef LOAD_ALIGN_MISALIGN_EN
        lat_test(32'h1001, 5'b00010, 5'd3, 5, 1'b1);
`else
        lat_test(32'h1001, 5'b00010, 5'd3, 1, 1'b0);
`endif
        issue(32'hFFFFFFFE, 5'b00110, 5'd4);
        drain();
        issue(32'h1004, 5'b00011, 5'd5);
        drain();

        // Backpressure on both the bus request and writeback.
        bus_rdy_mode = 0;
        wb_rdy_mode = 0;
        issue(32'h2000, 5'b00010, 5'd7);
        a0 = bus_addr;
        c0 = wb_count;
        for (int i = 0; i < 3; i++) begin
            chk("bp_bus_valid", bus_req_valid, 1);
            chk("bp_bus_addr", bus_addr, a0);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        bus_rdy_mode = 1;
        n = 0;
        while (!wb_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("bp_wb_timeout");
        d0 = wb_data;
        r0 = wb_rd;
        for (int i = 0; i < 5; i++) begin
            chk("bp_wb_valid", wb_valid, 1);
            chk("bp_wb_data", wb_data, d0);
            chk("bp_wb_rd", wb_rd, r0);
            chk("bp_req_ready_wb", req_ready, 0);
            @(negedge clk);
        end
        chk("bp_no_early_wb", wb_count, c0);
        wb_rdy_mode = 1;
        drain();
        repeat (3) @(negedge clk);
        chk("bp_one_wb", wb_count, c0 + 1);
        bus_rdy_mode = 2;
        wb_rdy_mode = 2;

        // Reset while waiting for the final read response.
        bus_rdy_mode = 1;
        wb_rdy_mode = 1;
        rsp_hold = 1'b1;
`ifdef LOAD_ALIGN_MISALIGN_EN
        issue(32'h3002, 5'b00010, 5'd9);
`else
        issue(32'h3000, 5'b00010, 5'd9);
`endif
        n = 0;
        while (bus_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("rst_test_bus_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        wb_q.delete();
        bus_q.delete();
        @(negedge clk);
        rsp_hold = 1'b0;
        chk("mid_rst_bus_req_valid", bus_req_valid, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        chk("mid_rst_wb_rd", wb_rd, 0);
        chk("mid_rst_fault", misalign_fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        mem[32'h0] = 32'h000000A5;
        issue(32'h0, 5'b00000, 5'd10);
        drain();
        bus_rdy_mode = 2;
        wb_rdy_mode = 2;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else addr = $urandom & 32'h0000FFFF;
            issue(addr, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("final_wb_q_empty", wb_q.size(), 0);
        chk("final_bus_q_empty", bus_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
